// File: rtl/gray_arb_pkg.sv
// Shared helpers for the round-robin Gray conversion front end:
// width-generic Gray conversion, round-robin winner search and ID sizing.
package gray_arb_pkg;

  localparam int MAX_W    = 64;
  localparam int MAX_REQ  = 32;
  localparam int DEF_N    = 8;
  localparam int DEF_NREQ = 4;
  localparam int DEF_ID_W = $clog2(DEF_NREQ);

  typedef struct packed {
    logic        found;
    logic [31:0] winner;
  } pick_t;

  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Callers zero-extend narrower words; the MSB of the real word then
  // passes through unchanged because the bit above it is zero.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // First valid index at or after ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int unsigned nreq,
                                    input logic [31:0] ptr);
    pick_t res;
    logic [31:0] idx;
    logic [MAX_REQ-1:0] rot;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % nreq;
      rot = valid >> idx;
      if ((k < nreq) && !res.found && rot[0]) begin
        res.found  = 1'b1;
        res.winner = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/binary_to_gray1.sv
// Combinational N-bit binary to Gray converter.
module binary_to_gray1
  import gray_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = N'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among NREQ
// requesters, with a single registered output stage and valid/ready on both sides.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int NREQ = DEF_NREQ,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_binary,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_gray,
  output logic [N-1:0]      out_binary,
  output logic [ID_W-1:0]   out_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            accept;
  logic            grant;
  logic [N-1:0]    word;
  logic [N-1:0]    word_gray;
  pick_t           pick;

  // Grant is recomputed every cycle, so a requester that withdraws early
  // simply drops out of the search; reset forces all ready bits low.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), NREQ, 32'(ptr));
    winner    = ID_W'(pick.winner);
    accept    = !out_valid || out_ready;
    grant     = !rst && accept && pick.found;
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
    word      = req_binary[winner*N +: N];
  end

  binary_to_gray1 #(.N(N)) u_conv (
    .bin  (word),
    .gray (word_gray)
  );

  // No skid buffer: a grant refills the register in the same edge it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_binary <= '0;
      out_id     <= '0;
    end else if (grant) begin
      ptr        <= winner + 1'b1;
      out_valid  <= 1'b1;
      out_gray   <= word_gray;
      out_binary <= word;
      out_id     <= winner;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
